// File: rtl/frame_11011_tx.sv
// frame_11011_tx: serial framer emitting preamble 11011, zero-stuffed MSB-first payload, then an idle gap.
module frame_11011_tx #(
  parameter int DATA_W = 8,
  parameter int GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_done
);
  localparam int CA = $clog2(DATA_W + 1);
  localparam int CB = $clog2(GAP + 1);
  localparam int CM = CA > CB ? CA : CB;
  localparam int CW = CM > 3 ? CM : 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_DATA = 3'd2, S_STUFF = 3'd3, S_GAP = 3'd4;
  localparam logic [4:0] PAT = 5'b11011;
  localparam logic [2:0] S_END = GAP > 0 ? S_GAP : S_IDLE;
  localparam logic [CW-1:0] END_CNT = CW'(GAP > 0 ? GAP - 1 : 0);
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic ser_q, ser_d, done_q, done_d;
  assign in_ready = (state_q == S_IDLE) && !rst;
  assign busy = state_q != S_IDLE;
  assign ser_out = ser_q;
  assign frame_done = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid && in_ready) begin
        state_d = S_PRE;
        cnt_d = CW'(4);
        sh_d = in_data;
      end
      S_PRE: if (cnt_q == '0) begin
        state_d = S_DATA;
        cnt_d = CW'(DATA_W - 1);
      end else cnt_d = cnt_q - CW'(1);
      S_DATA: begin
        sh_d = sh_q << 1;
        if (sh_q[DATA_W-1]) state_d = S_STUFF;
        else if (cnt_q == '0) begin
          state_d = S_END;
          cnt_d = END_CNT;
          done_d = 1'b1;
        end else cnt_d = cnt_q - CW'(1);
      end
      // a stuffed 0 completes the bit it follows, so the bit count moves here
      S_STUFF: if (cnt_q == '0) begin
        state_d = S_END;
        cnt_d = END_CNT;
        done_d = 1'b1;
      end else begin
        state_d = S_DATA;
        cnt_d = cnt_q - CW'(1);
      end
      S_GAP: if (cnt_q == '0) state_d = S_IDLE;
      else cnt_d = cnt_q - CW'(1);
      default: state_d = S_IDLE;
    endcase
    ser_d = state_d == S_PRE ? PAT[cnt_d[2:0]] : (state_d == S_DATA) && sh_d[DATA_W-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      ser_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      ser_q <= ser_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_frame_11011_tx.sv
// tb_frame_11011_tx: frame-level reference model checked every cycle against two framer configurations.
module tb_frame_11011_tx;
  localparam logic [4:0] PAT = 5'b11011;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] vld = 2'b00;
  logic [1:0] rdy, ser, bsy, dn;
  logic [7:0] d8 = 8'h00;
  logic [3:0] d4 = 4'h0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc[$];
  int ndet = 0;
  int hn = 0;
  logic [4:0] hist = 5'b0;
  logic [3:0] q[2][$];
  logic [3:0] it[64];
  logic [3:0] mi[64];

  frame_11011_tx #(.DATA_W(8), .GAP(2)) u0 (.clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(d8), .ser_out(ser[0]), .busy(bsy[0]), .frame_done(dn[0]));
  frame_11011_tx #(.DATA_W(4), .GAP(0)) u1 (.clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(d4), .ser_out(ser[1]), .busy(bsy[1]), .frame_done(dn[1]));

  always #5 clk = ~clk;

  task automatic chk(input int u, input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL u%0d %s: got %0h expected %0h at cycle %0d", u, nm, a, e, cyc);
    end
  endtask

  // items per cycle: {preamble_end, frame_done, busy, ser}
  function automatic int build(input logic [7:0] d, input int w, input int gap, output logic [3:0] o[64]);
    int n = 0;
    for (int i = 0; i < 5; i++) begin
      o[n] = {i == 4, 1'b0, 1'b1, PAT[4-i]};
      n++;
    end
    for (int i = w - 1; i >= 0; i--) begin
      o[n] = {2'b00, 1'b1, d[i]};
      n++;
      if (d[i]) begin
        o[n] = 4'b0010;
        n++;
      end
    end
    for (int g = 0; g < gap; g++) begin
      o[n] = {1'b0, g == 0, 1'b1, 1'b0};
      n++;
    end
    if (gap == 0) begin
      o[n] = 4'b0100;
      n++;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      logic [3:0] c;
      logic er, dt;
      int n;
      c = q[u].size() > 0 ? q[u][0] : 4'b0000;
      er = !rst && !c[1];
      chk(u, "ser", 32'(ser[u]), 32'(c[0]));
      chk(u, "busy", 32'(bsy[u]), 32'(c[1]));
      chk(u, "done", 32'(dn[u]), 32'(c[2]));
      chk(u, "ready", 32'(rdy[u]), 32'(er));
      if (u == 0) begin
        hist = {hist[3:0], ser[0]};
        hn++;
        dt = hn >= 5 && hist == PAT;
        if (dt) begin
          hn = 0;
          ndet++;
        end
        chk(0, "detect", 32'(dt), 32'(c[3]));
      end
      if (rst) q[u].delete();
      else begin
        if (q[u].size() > 0) void'(q[u].pop_front());
        if (vld[u] && er) begin
          n = build(u == 1 ? {4'b0, d4} : d8, u == 1 ? 4 : 8, u == 1 ? 0 : 2, it);
          for (int k = 0; k < n; k++) q[u].push_back(it[k]);
          if (u == 0) hs_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input int u, input logic [7:0] d, input int len, input logic [31:0] exp);
    logic [31:0] got;
    int t;
    @(posedge clk) #1;
    vld[u] = 1'b1;
    if (u == 1) d4 = d[3:0];
    else d8 = d;
    t = 0;
    @(negedge clk);
    while (!rdy[u] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[u]) chk(u, "handshake_timeout", 0, 1);
    @(posedge clk) #1;
    vld[u] = 1'b0;
    if (len > 0) begin
      got = 0;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        got = {got[30:0], ser[u]};
      end
      chk(u, "frame_bits", got, exp);
    end
  endtask

  initial begin
    int n, h0, nd0, nf0;
    logic [31:0] v;
    logic alt;
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, h0, nd0, nf0;
    logic [31:0] v;
    logic alt;
    n = build(8'hA5, 8, 2, mi);
    chk(0, "model_len_a5", n, 19);
    v = 0;
    for (int k = 0; k < n; k++) v = {v[30:0], mi[k][0]};
    chk(0, "model_bits_a5", v, 32'b1101110010001001000);
    chk(0, "model_done_a5", 32'(mi[17][2]), 1);
    n = build(8'hFF, 8, 2, mi);
    chk(0, "model_len_ff", n, 23);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(0, "reset_ready", 32'(rdy[0]), 0);
    chk(0, "reset_ser", 32'(ser[0]), 0);
    @(posedge clk) #1;
    rst = 1'b0;
    send(0, 8'hA5, 19, 32'b1101110010001001000);
    @(negedge clk);
    chk(0, "a5_ready_c20", 32'(rdy[0]), 1);
    chk(0, "a5_busy_c20", 32'(bsy[0]), 0);
    send(0, 8'h00, 15, 32'b110110000000000);
    send(0, 8'hFF, 23, 32'b11011101010101010101000);
    @(posedge clk) #1;
    h0 = hs_cyc.size();
    alt = 1'b0;
    vld[0] = 1'b1;
    repeat (120) begin
      if (rdy[0]) begin
        d8 = alt ? 8'h00 : 8'hFF;
        alt = ~alt;
      end else d8 = 8'($urandom);
      @(posedge clk) #1;
    end
    vld[0] = 1'b0;
    chk(0, "b2b_gap_ff", hs_cyc[h0+1] - hs_cyc[h0], 24);
    chk(0, "b2b_gap_00", hs_cyc[h0+2] - hs_cyc[h0+1], 16);
    repeat (30) @(posedge clk);
    send(0, 8'hA5, 0, 0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk(0, "rst_ready_low", 32'(rdy[0]), 0);
    @(posedge clk) #1;
    @(negedge clk);
    chk(0, "rst_ser", 32'(ser[0]), 0);
    chk(0, "rst_busy", 32'(bsy[0]), 0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk(0, "rst_release_ready", 32'(rdy[0]), 1);
    send(0, 8'h81, 17, 32'b11011100000001000);
    nd0 = ndet;
    nf0 = hs_cyc.size();
    for (int i = 0; i < 100; i++) begin
      send(0, 8'($urandom), 0, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (30) @(posedge clk);
    chk(0, "detect_count", ndet - nd0, hs_cyc.size() - nf0);
    send(1, 8'h0B, 12, 32'b110111001010);
    @(negedge clk);
    chk(1, "g0_done_idle", 32'(dn[1]), 1);
    chk(1, "g0_ready_idle", 32'(rdy[1]), 1);
    @(posedge clk) #1;
    vld[1] = 1'b1;
    repeat (60) begin
      d4 = 4'($urandom);
      @(posedge clk) #1;
    end
    vld[1] = 1'b0;
    repeat (20) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_11011_tx.md
Name: frame_11011_tx

Overview:
- Serial frame transmitter that pairs with the on-chip Mealy 11011 non-overlapping detector.
- Accepts a parallel data word over a valid/ready handshake and emits a single-bit stream: preamble 11011, then the data MSB-first with bit-stuffing, then an idle gap.
- Stuffing inserts a 0 after every data 1, so the detector fires exactly once per frame, on the preamble.
- Its ser_out drives the detector's serial input in loopback, and an external pin in the top level.

Parameters:
DATA_W, 8, payload width in bits; legal range 1 or more.
GAP, 2, number of forced-0 idle cycles after each frame; legal range 0 or more.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  source presents in_data.
in_ready  output  1  transmitter can accept a word.
in_data  input  DATA_W  payload word; sampled on handshake only.
ser_out  output  1  serial bit stream; registered.
busy  output  1  frame in progress (preamble, data, stuff or gap).
frame_done  output  1  one-cycle pulse at end of the data/stuff phase.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; ser_out=0, busy=0, frame_done=0.
  - in_ready=0 while rst is high.
  - A reset mid-frame aborts the frame immediately. No partial bits are emitted after the reset edge.
- in_ready = (state==IDLE) & ~rst. It is combinational from registered state.
- Handshake: the transfer happens at the edge where in_valid & in_ready. in_data is latched into a shift register. in_valid is ignored in every non-IDLE state.
- States:
  - IDLE:
    - ser_out=0, busy=0.
    - On handshake, go to PRE with bit index 4.
  - PRE:
    - 5 cycles; ser_out = 1,1,0,1,1 in order; busy=1.
    - Then go to DATA.
  - DATA:
    - ser_out = current MSB of the shift register; busy=1.
    - If the bit is 1, the next state is STUFF. Otherwise advance to the next bit.
    - After the last bit, go to GAP, or to IDLE if GAP=0, unless a STUFF is pending.
  - STUFF:
    - ser_out=0 for 1 cycle.
    - Then go to the next DATA bit, or end the frame as above.
  - GAP:
    - ser_out=0, busy=1 for GAP cycles.
    - Then go to IDLE.
- frame_done: high for exactly one cycle. That cycle is the first cycle after the final DATA/STUFF bit, which is the first GAP cycle, or the first IDLE cycle when GAP=0.
- Latency: the first preamble bit appears on ser_out in the cycle after the handshake edge.
- Frame length L = 5 + DATA_W + popcount(data) + GAP cycles.
  - busy stays high for exactly L consecutive cycles.
  - in_ready returns high in the cycle after the last busy cycle.
- Back-to-back operation: with in_valid held high, successive handshakes are L+1 cycles apart. Nothing is emitted in the IDLE cycle between frames, so ser_out=0 there.
- Stream guarantee: data and stuff bits never contain "11". The only 11011 in any stream is the preamble, independent of the data and of the previous frame.
- Counters are sized with $clog2 from DATA_W and GAP. GAP=0 must synthesize, with the gap counter elided.

Test Plan:
1. Reset, then in_valid=1, in_data=8'hA5 → ser_out over 19 cycles = 11011 100100010010 00; busy high 19 cycles; frame_done pulses on cycle 18 of the frame (first gap cycle); in_ready high again on cycle 20.
2. in_data=8'h00 → 11011 00000000 00; L=15. in_data=8'hFF → 11011 1010101010101010 00; L=23; no "11" in the data region.
3. in_valid held high with alternating words 8'hFF and 8'h00 → handshakes 24 then 16 cycles apart; in_data changes during busy are ignored; each frame's bits exactly match the word latched at its handshake.
4. Assert rst during the DATA phase of an 8'hA5 frame → ser_out=0 and busy=0 from the next cycle; no frame_done; in_ready=0 while rst is high, then 1 in the first cycle after release; a new 8'h81 frame then transmits correctly.
5. Loopback: ser_out drives the 11011 detector with 100 random words. The detector pulses exactly once per frame, at the last preamble bit, and never during data/stuff/gap.
6. GAP=0, DATA_W=4, in_data=4'hB → 11011 1001010 (L=12); frame_done coincides with the IDLE cycle; the next handshake is accepted that same cycle.
